mem_lsu: RTL

- Load/store unit sitting downstream of the execute stage. Consumes the effective address (ALU result), the store data (rs2) and the funct3 of the memory instruction.
- Drives a request/grant/response data-memory bus: byte-lane strobes on stores, sign/zero-extended load data on loads.
- Stalls the core until the access completes.
- Flags misaligned accesses and bus faults, without touching the bus for a misaligned access.

---
 rtl/mem_lsu_if.sv | 8 +
 rtl/mem_lsu.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/grant/response data-memory bus between the LSU (master) and memory (slave)
interface mem_lsu_if;
  logic req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] wstrb;
  modport master(output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata, err);
  modport slave(input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit with lane steering, load extension and misalign/fault flags; define LSU_TIMEOUT_EN for a bus timeout
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        access_fault,
  mem_lsu_if.master   bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_n;
  logic op, is_b, is_h, uns, mis, to_hit;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext, wd;
  logic [3:0] ws;
  assign op = mem_read | mem_write;
  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign uns = funct3[2];
  assign mis = is_h ? alu_result[0] : !is_b && alu_result[1:0] != 2'b00;
  assign stall = op && state != DONE && !rst;
  assign b = 8'(bus.rdata >> {alu_result[1:0], 3'b000});
  assign h = alu_result[1] ? bus.rdata[31:16] : bus.rdata[15:0];
  assign ext = is_b ? {{24{!uns && b[7]}}, b} : is_h ? {{16{!uns && h[15]}}, h} : bus.rdata;
  assign wd = is_b ? {4{rdata2[7:0]}} : is_h ? {2{rdata2[15:0]}} : rdata2;
  assign ws = !mem_write ? 4'b0000 : is_b ? 4'b0001 << alu_result[1:0] :
              is_h ? (alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef LSU_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  assign to_hit = (state == REQ || state == RESP) && to_cnt == TO_W'(TIMEOUT_CYCLES - 1) &&
                  !(state == RESP && bus.rvalid);
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= state == IDLE ? '0 : to_cnt + 1'b1;
`else
  logic unused_to;
  assign to_hit = 1'b0;
  assign unused_to = TIMEOUT_CYCLES > 0 && TO_W > 0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = op ? (mis ? DONE : REQ) : IDLE;
      REQ: state_n = bus.gnt ? RESP : REQ;
      RESP: state_n = bus.rvalid ? DONE : RESP;
      default: state_n = IDLE;
    endcase
    if (to_hit) state_n = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.req <= 1'b0;
      bus.we <= 1'b0;
      bus.addr <= '0;
      bus.wdata <= '0;
      bus.wstrb <= '0;
      load_data <= '0;
      misalign <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (op) begin
          misalign <= mis;
          access_fault <= 1'b0;
          if (!mis) begin
            bus.req <= 1'b1;
            bus.we <= mem_write;
            bus.addr <= {alu_result[31:2], 2'b00};
            bus.wdata <= wd;
            bus.wstrb <= ws;
          end
        end
        REQ: if (bus.gnt) bus.req <= 1'b0;
        RESP: if (bus.rvalid) begin
          if (!bus.we) load_data <= ext;
          access_fault <= bus.err;
        end
        default: ;
      endcase
      if (to_hit) begin
        bus.req <= 1'b0;
        access_fault <= 1'b1;
      end
    end
endmodule
